sn74121: RTL and testbench

Synchronous model of one SN74121 non-retriggerable monostable multivibrator, for the timing-pulse chains that drive the JK flip-flop clock and clear inputs. Asynchronous trigger pins are sampled on `mclk`, synchronised, and edge-detected. Each qualifying trigger produces one `q` pulse of exactly `PULSE_CYCLES` master clocks, followed by a recovery holdoff. Typical use is a delay-line stage whose `q_n` feeds a flip-flop `clk_n`.

---
 rtl/sn74121_pkg.sv | 17 +
 rtl/sn74121_if.sv | 13 +
 rtl/sn74121_sync_edge.sv | 30 +++
 rtl/sn74121.sv | 117 +++++++++++
 tb/tb_sn74121.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sn74121_pkg.sv
// rtl/sn74121_pkg.sv - shared types and constants for the sn74121 monostable model.
package sn74121_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    RECOVER
  } state_e;

  localparam int   SYNC_STAGES = 2;
  localparam logic T_PREV_RST  = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sn74121_if.sv
// rtl/sn74121_if.sv - trigger pins and pulse outputs of one sn74121 stage.
interface sn74121_if;

  logic a1_n;
  logic a2_n;
  logic b;
  logic q;
  logic q_n;

  modport master (output a1_n, a2_n, b, input q, q_n);
  modport slave  (input a1_n, a2_n, b, output q, q_n);

endinterface

// File: rtl/sn74121_sync_edge.sv
// rtl/sn74121_sync_edge.sv - 2-flop synchroniser plus one registered previous value.
module sync_edge
  import sn74121_pkg::*;
#(
  parameter logic PREV_RST = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic sync_o,
  output logic prev_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= PREV_RST;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign prev_o = prev_q;

endmodule

// File: rtl/sn74121.sv
// rtl/sn74121.sv - synchronous SN74121 one-shot; SN74121_RETRIG_EN selects retriggerable mode.
module sn74121
  import sn74121_pkg::*;
#(
  parameter int PULSE_CYCLES   = 20,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic       mclk,
  input  logic       mrst,
  sn74121_if.slave   bus
);

  localparam int             CW           = $clog2(max_int(PULSE_CYCLES, RECOVER_CYCLES) + 1);
  localparam logic [CW-1:0]  PULSE_LOAD   = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0]  RECOVER_LOAD = (RECOVER_CYCLES > 0) ? CW'(RECOVER_CYCLES - 1) : '0;
  localparam logic [CW-1:0]  CNT_ONE      = CW'(1);

  logic a1s_n, a2s_n, bs;
  logic a1p_n, a2p_n, bp;

  // Previous-value flops reset so that t_prev (their decoded level) comes out of reset as T_PREV_RST.
  sync_edge #(.PREV_RST(~T_PREV_RST)) u_sync_a1 (
    .clk_i  (mclk),
    .rst_i  (mrst),
    .d_i    (bus.a1_n),
    .sync_o (a1s_n),
    .prev_o (a1p_n)
  );

  sync_edge #(.PREV_RST(~T_PREV_RST)) u_sync_a2 (
    .clk_i  (mclk),
    .rst_i  (mrst),
    .d_i    (bus.a2_n),
    .sync_o (a2s_n),
    .prev_o (a2p_n)
  );

  sync_edge #(.PREV_RST(T_PREV_RST)) u_sync_b (
    .clk_i  (mclk),
    .rst_i  (mrst),
    .d_i    (bus.b),
    .sync_o (bs),
    .prev_o (bp)
  );

  logic trig_lvl;
  logic t_prev;
  logic trig_evt;

  assign trig_lvl = (~a1s_n | ~a2s_n) & bs;
  assign t_prev   = (~a1p_n | ~a2p_n) & bp;
  assign trig_evt = trig_lvl & ~t_prev;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_q, q_d;
  logic          q_n_q;

  always_ff @(posedge mclk) begin
    if (mrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      q_n_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      q_n_q   <= ~q_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    case (state_q)
      IDLE: begin
        if (trig_evt) begin
          cnt_d   = PULSE_LOAD;
          q_d     = 1'b1;
          state_d = PULSE;
        end
      end
      PULSE: begin
`ifdef SN74121_RETRIG_EN
        if (trig_evt) begin
          cnt_d = PULSE_LOAD;
        end else
`endif
        if (cnt_q == '0) begin
          q_d = 1'b0;
          if (RECOVER_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            cnt_d   = RECOVER_LOAD;
            state_d = RECOVER;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RECOVER: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.q   = q_q;
  assign bus.q_n = q_n_q;

endmodule

// File: tb/tb_sn74121.sv
// tb/tb_sn74121.sv - self-checking bench for sn74121 with an interval-based reference model.
module tb_sn74121;
  import sn74121_pkg::*;

  localparam int P   = 20;
  localparam int R   = 2;
  localparam int HSZ = 16384;

  logic mclk;
  logic mrst;
  logic mrst2;

  sn74121_if bus();
  sn74121_if bus2();

  sn74121 #(.PULSE_CYCLES(P), .RECOVER_CYCLES(R)) dut (
    .mclk (mclk),
    .mrst (mrst),
    .bus  (bus)
  );

  sn74121 #(.PULSE_CYCLES(1), .RECOVER_CYCLES(0)) dut2 (
    .mclk (mclk),
    .mrst (mrst2),
    .bus  (bus2)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit cmp_en = 1'b0;

  bit h_rst  [HSZ];
  bit h_tin  [HSZ];
  bit h_tlev [HSZ];
  bit q_hist [HSZ];

  int m_start = -1000;
  int m_end   = -1000;
  bit exp_q   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: pulses are intervals [m_start, m_end] of edge indices; T seen
  // at edge n is the input level sampled two edges earlier, blanked by any reset in between.
  always @(posedge mclk) begin
    int n;
    bit tlev;
    bit tprev;
    cyc = cyc + 1;
    n   = cyc;
    if (n < HSZ) begin
      h_rst[n] = mrst;
      h_tin[n] = (!bus.a1_n || !bus.a2_n) && bus.b;
      if (n < 3) begin
        tlev  = 1'b0;
        tprev = 1'b1;
      end else begin
        tlev  = (h_rst[n-1] || h_rst[n-2]) ? 1'b0 : h_tin[n-2];
        tprev = h_rst[n-1] ? 1'b1 : h_tlev[n-1];
      end
      h_tlev[n] = tlev;
      if (mrst) begin
        m_start = -1000;
        m_end   = -1000;
      end else if (tlev && !tprev) begin
        if (n >= m_end + R + 2) begin
          m_start = n;
          m_end   = n + P - 1;
        end
`ifdef SN74121_RETRIG_EN
        else if (n > m_start && n <= m_end + 1) begin
          m_end = n + P - 1;
        end
`endif
      end
      exp_q = !mrst && (n >= m_start) && (n <= m_end);
    end
  end

  always @(negedge mclk) begin
    if (cyc < HSZ) q_hist[cyc] = bus.q;
    if (cmp_en) begin
      chk("q_model", int'(bus.q), int'(exp_q));
      chk("q_n_model", int'(bus.q_n), int'(!exp_q));
    end
  end

  function automatic int count_high(input int from, input int to);
    int c = 0;
    for (int i = from; i <= to; i++) if (i >= 0 && i < HSZ && q_hist[i]) c++;
    return c;
  endfunction

  function automatic int first_rise(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      if (i > 0 && i < HSZ && q_hist[i] && !q_hist[i-1]) return i;
    end
    return -1;
  endfunction

  task automatic wait_cyc(input int e);
    int guard = 0;
    while (cyc < e && guard < 20000) begin
      @(negedge mclk);
      guard++;
    end
    if (guard >= 20000) chk("wait_timeout", cyc, e);
  endtask

  // Drive b so that the new level is first sampled at edge e.
  task automatic set_b(input int e, input logic v);
    wait_cyc(e - 1);
    if (cyc != e - 1) chk("schedule", cyc, e - 1);
    bus.b = v;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, s, s2, hi, adj, qnb;
    bit prevq;
    mrst      = 1'b1;
    mrst2     = 1'b1;
    bus.a1_n  = 1'b0;
    bus.a2_n  = 1'b1;
    bus.b     = 1'b1;
    bus2.a1_n = 1'b0;
    bus2.a2_n = 1'b1;
    bus2.b    = 1'b0;

    repeat (4) @(negedge mclk);
    chk("reset_q", int'(bus.q), 0);
    chk("reset_q_n", int'(bus.q_n), 1);
    cmp_en = 1'b1;
    mrst   = 1'b0;

    // Reset release with T high, then a clean B rising edge.
    repeat (40) @(negedge mclk);
    bus.b = 1'b0;
    repeat (3) @(negedge mclk);
    bus.b = 1'b1;
    k = cyc + 1;
    wait_cyc(k + 40);
    chk("a_latency", first_rise(k, k + 10) - k, 2);
    chk("a_width", count_high(k, k + 40), P);

    // A1 falling edge with B high, A2 high.
    bus.a1_n = 1'b1;
    bus.a2_n = 1'b1;
    repeat (6) @(negedge mclk);
    bus.a1_n = 1'b0;
    k = cyc + 1;
    wait_cyc(k + 40);
    chk("b_latency", first_rise(k, k + 10) - k, 2);
    chk("b_width", count_high(k, k + 40), P);

    // Both A high: B toggling must not fire.
    bus.a1_n = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      bus.b = ~bus.b;
      repeat (2) @(negedge mclk);
    end
    wait_cyc(k + 25);
    chk("b_no_pulse", count_high(k + 3, k + 25), 0);

    // Second trigger 10 cycles into the pulse, and one 1 cycle into recovery.
    bus.a1_n = 1'b0;
    bus.b    = 1'b0;
    repeat (5) @(negedge mclk);
    bus.b = 1'b1;
    k = cyc + 1;
    s = k + 2;
    set_b(s + 5, 1'b0);
    set_b(s + 8, 1'b1);
`ifdef SN74121_RETRIG_EN
    wait_cyc(s + 70);
    chk("c_rise", first_rise(k, s + 5), s);
    chk("c_width", count_high(s - 2, s + 70), 30);
`else
    set_b(s + 15, 1'b0);
    set_b(s + 19, 1'b1);
    wait_cyc(s + 70);
    chk("c_rise", first_rise(k, s + 5), s);
    chk("c_width", count_high(s - 2, s + 70), P);
`endif

    // Reset at pulse cycle 7, B held high afterwards.
    bus.b = 1'b0;
    repeat (5) @(negedge mclk);
    bus.b = 1'b1;
    k = cyc + 1;
    s = k + 2;
    wait_cyc(s + 6);
    mrst = 1'b1;
    @(negedge mclk);
    mrst = 1'b0;
    chk("d_reset_q", int'(bus.q), 0);
    chk("d_reset_q_n", int'(bus.q_n), 1);
    wait_cyc(s + 60);
    chk("d_trunc_width", count_high(s, s + 7), 7);
    chk("d_refire", first_rise(s + 8, s + 40), s + 10);
    chk("d_refire_width", count_high(s + 8, s + 60), P);

    // Trigger on the last recovery cycle is ignored; one cycle later it is accepted.
    bus.b = 1'b0;
    repeat (5) @(negedge mclk);
    bus.b = 1'b1;
    k = cyc + 1;
    s = k + 2;
    set_b(s + 10, 1'b0);
    set_b(s + 20, 1'b1);
    wait_cyc(s + 50);
    chk("f_ignored", count_high(s + P, s + 50), 0);
    bus.b = 1'b0;
    repeat (5) @(negedge mclk);
    bus.b = 1'b1;
    k  = cyc + 1;
    s2 = k + 2;
    set_b(s2 + 10, 1'b0);
    set_b(s2 + 21, 1'b1);
    wait_cyc(s2 + 50);
    chk("f_accepted", first_rise(s2 + P, s2 + 40), s2 + 23);

    // PULSE_CYCLES=1, RECOVER_CYCLES=0 with B toggling every 2 cycles.
    mrst2 = 1'b0;
    hi    = 0;
    adj   = 0;
    qnb   = 0;
    prevq = 1'b0;
    for (int i = 0; i < 48; i++) begin
      if (i % 2 == 0) bus2.b = ~bus2.b;
      @(negedge mclk);
      if (i >= 8) begin
        if (bus2.q) hi++;
        if (bus2.q && prevq) adj++;
        if (bus2.q_n !== ~bus2.q) qnb++;
      end
      prevq = bus2.q;
    end
    chk("e_high_count", hi, 10);
    chk("e_adjacent", adj, 0);
    chk("e_qn", qnb, 0);

    // Randomised triggers and occasional resets against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) bus.b = ~bus.b;
      if ($urandom_range(0, 9) == 0) bus.a1_n = ~bus.a1_n;
      if ($urandom_range(0, 9) == 0) bus.a2_n = ~bus.a2_n;
      mrst = ($urandom_range(0, 199) == 0);
      @(negedge mclk);
    end
    mrst = 1'b0;
    repeat (4) @(negedge mclk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
